// File: rtl/disp_scan_mux_if.sv
// Bus bundle for the four-digit scan driver: load/value/blanking in,
// selected nibble, anode enables and frame pulse out.
interface disp_scan_mux_if;
    logic        load;
    logic [15:0] value;
    logic        blank_lz;
    logic        N3;
    logic        N2;
    logic        N1;
    logic        N0;
    logic [3:0]  AN;
    logic        frame;

    modport master (
        output load, value, blank_lz,
        input  N3, N2, N1, N0, AN, frame
    );

    modport slave (
        input  load, value, blank_lz,
        output N3, N2, N1, N0, AN, frame
    );
endinterface

// File: rtl/disp_scan_mux.sv
// Time-multiplexed scan driver for a 4-digit common-anode display with
// frame-aligned double buffering and leading-zero blanking.
module disp_scan_mux #(
    parameter int unsigned PRESCALE = 50000,
    parameter int unsigned BLANK    = 2
) (
    input logic            clk,
    input logic            rst_n,
    disp_scan_mux_if.slave bus
);
    localparam int unsigned      CntW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CntW-1:0] CntLast  = CntW'(PRESCALE - 1);
    localparam logic [CntW-1:0] CntBlank = CntW'(BLANK);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      idx_q, idx_d;
    logic [15:0]     active_q, active_d;
    logic [15:0]     shadow_q, shadow_d;
    logic            pending_q, pending_d;
    logic [3:0]      nib_q, nib_d;
    logic [3:0]      an_q, an_d;
    logic            frame_q;
    logic            terminal, wrap, upper_zero;

    always_comb begin
        terminal  = (cnt_q == CntLast);
        wrap      = terminal && (idx_q == 2'd3);
        cnt_d     = terminal ? '0 : cnt_q + CntW'(1);
        idx_d     = terminal ? idx_q + 2'd1 : idx_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        active_d  = active_q;

        if (bus.load) begin
            shadow_d  = bus.value;
            pending_d = 1'b1;
        end
        // A load coinciding with the wrap edge bypasses the shadow.
        if (wrap) begin
            if (bus.load) begin
                active_d  = bus.value;
                pending_d = 1'b0;
            end else if (pending_q) begin
                active_d  = shadow_q;
                pending_d = 1'b0;
            end
        end

        // Outputs are a function of the post-edge state.
        nib_d = active_d[{idx_d, 2'b00} +: 4];
        case (idx_d)
            2'd1:    upper_zero = (active_d[15:4] == 12'h000);
            2'd2:    upper_zero = (active_d[15:8] == 8'h00);
            2'd3:    upper_zero = (active_d[15:12] == 4'h0);
            default: upper_zero = 1'b0;
        endcase

        if ((cnt_d < CntBlank) || (bus.blank_lz && upper_zero)) begin
            an_d = 4'hF;
        end else begin
            an_d = ~(4'b0001 << idx_d);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            idx_q     <= 2'd0;
            active_q  <= 16'h0000;
            shadow_q  <= 16'h0000;
            pending_q <= 1'b0;
            nib_q     <= 4'h0;
            an_q      <= 4'hF;
            frame_q   <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            active_q  <= active_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            nib_q     <= nib_d;
            an_q      <= an_d;
            frame_q   <= wrap;
        end
    end

    assign bus.N3    = nib_q[3];
    assign bus.N2    = nib_q[2];
    assign bus.N1    = nib_q[1];
    assign bus.N0    = nib_q[0];
    assign bus.AN    = an_q;
    assign bus.frame = frame_q;
endmodule

// File: tb/tb_disp_scan_mux.sv
// Self-checking bench for disp_scan_mux: table vectors, directed corner
// sequences and random stimulus against a slot/frame arithmetic model.
module tb_disp_scan_mux;
    localparam int unsigned P = 4;
    localparam int unsigned B = 1;
    localparam int unsigned FRAME = 4 * P;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    disp_scan_mux_if bus ();

    disp_scan_mux #(
        .PRESCALE(P),
        .BLANK   (B)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model: elapsed edges since reset plus the double buffer contents.
    int unsigned m_t;
    logic [15:0] m_active;
    logic [15:0] m_shadow;
    bit          m_pend;

    typedef struct {
        logic [15:0] value;
        bit          lz;
        logic [15:0] exp_n;   // nibble i = N shown in slot i
        logic [15:0] exp_an;  // nibble i = AN during lit part of slot i
    } vec_t;

    vec_t tbl[7];

    function automatic logic [3:0] n_out();
        return {bus.N3, bus.N2, bus.N1, bus.N0};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic ld, input logic [15:0] v, input logic lz, output bit wrap);
        int unsigned cnt, idx;
        logic [15:0] sh;
        logic [3:0]  exp_an;
        bit          blanked;
        bus.load     = ld;
        bus.value    = v;
        bus.blank_lz = lz;
        @(posedge clk);
        wrap = ((m_t + 1) % FRAME) == 0;
        if (ld) begin
            m_shadow = v;
            m_pend   = 1'b1;
        end
        if (wrap) begin
            if (ld) begin
                m_active = v;
                m_pend   = 1'b0;
            end else if (m_pend) begin
                m_active = m_shadow;
                m_pend   = 1'b0;
            end
        end
        m_t++;
        #1;
        cnt     = m_t % P;
        idx     = (m_t / P) % 4;
        sh      = m_active >> (4 * idx);
        blanked = lz && (idx != 0) && (sh == 16'h0);
        exp_an  = (cnt < B || blanked) ? 4'hF : ~(4'b0001 << idx);
        check("N", {12'h0, n_out()}, {12'h0, sh[3:0]});
        check("AN", {12'h0, bus.AN}, {12'h0, exp_an});
        check("frame", {15'h0, bus.frame}, {15'h0, wrap});
        check("one_anode", {15'h0, ($countones(~bus.AN) <= 1)}, 16'h1);
        bus.load = 1'b0;
    endtask

    // Entered just after a rising edge; asserts reset between edges.
    task automatic do_reset();
        bus.load = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("rst_N", {12'h0, n_out()}, 16'h0);
        check("rst_AN", {12'h0, bus.AN}, 16'hF);
        check("rst_frame", {15'h0, bus.frame}, 16'h0);
        m_t      = 0;
        m_active = 16'h0;
        m_shadow = 16'h0;
        m_pend   = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    task automatic run_to_wrap(input logic lz);
        bit w;
        for (int i = 0; i < 2 * FRAME; i++) begin
            step(1'b0, 16'h0, lz, w);
            if (w) return;
        end
        check("wrap_timeout", 16'h0, 16'h1);
    endtask

    initial begin
        bit w;
        int stale;
        logic lz;
        logic [15:0] v;

        tbl[0] = '{16'h1A3F, 1'b0, 16'h1A3F, 16'h7BDE};
        tbl[1] = '{16'h0042, 1'b1, 16'h0042, 16'hFFDE};
        tbl[2] = '{16'h0000, 1'b1, 16'h0000, 16'hFFFE};
        tbl[3] = '{16'h0000, 1'b0, 16'h0000, 16'h7BDE};
        tbl[4] = '{16'h0700, 1'b1, 16'h0700, 16'hFBDE};
        tbl[5] = '{16'h8001, 1'b1, 16'h8001, 16'h7BDE};
        tbl[6] = '{16'h00F0, 1'b1, 16'h00F0, 16'hFFDE};

        rst_n        = 1'b0;
        bus.load     = 1'b0;
        bus.value    = 16'h0;
        bus.blank_lz = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Plain scan with a load at cycle 5; model covers AN/N/frame each cycle.
        for (int i = 1; i <= 4; i++) step(1'b0, 16'h0, 1'b0, w);
        step(1'b1, 16'h1A3F, 1'b0, w);
        run_to_wrap(1'b0);
        check("commit_N", {12'h0, n_out()}, 16'hF);
        check("commit_AN", {12'h0, bus.AN}, 16'hF);
        check("commit_frame", {15'h0, bus.frame}, 16'h1);
        check("commit_t", m_t[15:0], 16'(FRAME));
        step(1'b0, 16'h0, 1'b0, w);
        check("commit_AN_lit", {12'h0, bus.AN}, 16'hE);

        // Load coinciding with the wrap edge beats an older pending value.
        step(1'b1, 16'h1111, 1'b0, w);
        for (int i = 0; i < 2 * FRAME && ((m_t + 1) % FRAME) != 0; i++) step(1'b0, 16'h0, 1'b0, w);
        step(1'b1, 16'h5555, 1'b0, w);
        check("wrapload_frame", {15'h0, bus.frame}, 16'h1);
        check("wrapload_N", {12'h0, n_out()}, 16'h5);
        stale = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            step(1'b0, 16'h0, 1'b0, w);
            if (n_out() != 4'h5) stale++;
        end
        check("wrapload_no_stale", stale[15:0], 16'h0);

        // Table vectors: commit each value, then check every slot's lit phase.
        foreach (tbl[k]) begin
            step(1'b1, tbl[k].value, tbl[k].lz, w);
            run_to_wrap(tbl[k].lz);
            for (int i = 0; i < FRAME; i++) begin
                step(1'b0, 16'h0, tbl[k].lz, w);
                if ((m_t % P) == P - 1) begin
                    check($sformatf("tbl%0d_N", k), {12'h0, n_out()},
                          {12'h0, tbl[k].exp_n[4 * ((m_t / P) % 4) +: 4]});
                    check($sformatf("tbl%0d_AN", k), {12'h0, bus.AN},
                          {12'h0, tbl[k].exp_an[4 * ((m_t / P) % 4) +: 4]});
                end
            end
        end

        // Dropping blank_lz relights digit 2 on the very next edge.
        step(1'b1, 16'h0042, 1'b1, w);
        run_to_wrap(1'b1);
        for (int i = 0; i < FRAME && (m_t % FRAME) != 2 * P + 1; i++) step(1'b0, 16'h0, 1'b1, w);
        check("lz_dark", {12'h0, bus.AN}, 16'hF);
        step(1'b0, 16'h0, 1'b0, w);
        check("lz_drop_AN", {12'h0, bus.AN}, 16'hB);

        // Reset at idx=2, cnt=2 with a load pending.
        step(1'b1, 16'hBEEF, 1'b0, w);
        for (int i = 0; i < 2 * FRAME && (m_t % FRAME) != 2 * P + 2; i++) step(1'b0, 16'h0, 1'b0, w);
        do_reset();
        stale = 0;
        for (int i = 0; i < FRAME + 1; i++) begin
            step(1'b0, 16'h0, 1'b0, w);
            if (n_out() != 4'h0) stale++;
        end
        check("midrst_no_commit", stale[15:0], 16'h0);

        // Random traffic, occasional mid-run resets.
        lz = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            v = 16'($urandom);
            case ($urandom_range(0, 3))
                0: v = v & 16'h000F;
                1: v = v & 16'h00FF;
                2: v = v & 16'h0FFF;
                default: ;
            endcase
            if ($urandom_range(0, 15) == 0) lz = ~lz;
            if ($urandom_range(0, 700) == 0) do_reset();
            else step(($urandom_range(0, 7) == 0), v, lz, w);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
